// File: rtl/bus_register_bank.sv
// Parametrised general-purpose register bank sharing one tri-state data bus, with two ALU read ports.
// Defining REG_BANK_SHADOW_EN adds a second, swappable shadow bank (i_SWAP / o_BANK).

module bus_register_bank_cell #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_en,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  inc_en,
  input  logic                  dec_en,
  output logic [DATA_WIDTH-1:0] o_val
);
  logic [DATA_WIDTH-1:0] val_q, val_d;

  // Load has priority; the parent never asserts inc and dec together.
  always_comb begin
    val_d = val_q;
    if (ld_en)       val_d = ld_data;
    else if (inc_en) val_d = val_q + DATA_WIDTH'(1);
    else if (dec_en) val_d = val_q - DATA_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign o_val = val_q;
endmodule

module bus_register_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                  i_CLOCK,
  input  logic                  i_CLEAR_N,
  inout  wire  [DATA_WIDTH-1:0] BUS,
  input  logic [SEL_WIDTH-1:0]  i_BUS_SEL,
  input  logic                  i_READ_BUS,
  input  logic                  i_WRITE_BUS,
  input  logic [SEL_WIDTH-1:0]  i_CNT_SEL,
  input  logic                  i_INC,
  input  logic                  i_DEC,
  input  logic [SEL_WIDTH-1:0]  i_SEL_A,
  input  logic [SEL_WIDTH-1:0]  i_SEL_B,
  output logic [DATA_WIDTH-1:0] o_DATA_A,
  output logic [DATA_WIDTH-1:0] o_DATA_B,
  output logic                  o_WRAP,
  output logic                  o_ZERO
`ifdef REG_BANK_SHADOW_EN
  ,
  input  logic                  i_SWAP,
  output logic                  o_BANK
`endif
);

`ifdef REG_BANK_SHADOW_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

  typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] bank_t;

  // Out-of-range selects match no register, so they read 0 and never enable a write.
  function automatic logic [DATA_WIDTH-1:0] pick(input bank_t arr, input logic [SEL_WIDTH-1:0] sel);
    pick = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (sel == SEL_WIDTH'(i)) pick = arr[i];
  endfunction

  function automatic logic in_range(input logic [SEL_WIDTH-1:0] sel);
    in_range = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (sel == SEL_WIDTH'(i)) in_range = 1'b1;
  endfunction

  logic [NUM_BANKS-1:0][NUM_REGS-1:0]                 ld_en, inc_en, dec_en;
  logic [NUM_BANKS-1:0][NUM_REGS-1:0][DATA_WIDTH-1:0] vals;
  bank_t                                              act;
  logic                                               bank;
  logic                                               cnt_go;
  logic [DATA_WIDTH-1:0]                              cnt_cur;
  logic                                               wrap_q, wrap_d, zero_q, zero_d;

  genvar b;
  generate
    for (b = 0; b < NUM_BANKS; b++) begin : g_bank
      bus_register_bank_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell [NUM_REGS-1:0] (
        .clk     (i_CLOCK),
        .rst_n   (i_CLEAR_N),
        .ld_en   (ld_en[b]),
        .ld_data ({NUM_REGS{BUS}}),
        .inc_en  (inc_en[b]),
        .dec_en  (dec_en[b]),
        .o_val   (vals[b])
      );
    end
  endgenerate

`ifdef REG_BANK_SHADOW_EN
  logic bank_q, bank_d;

  assign bank_d = bank_q ^ i_SWAP;
  assign bank   = bank_q;
  assign act    = bank_q ? vals[1] : vals[0];
  assign o_BANK = bank_q;

  always_ff @(posedge i_CLOCK or negedge i_CLEAR_N) begin
    if (!i_CLEAR_N) bank_q <= 1'b0;
    else            bank_q <= bank_d;
  end
`else
  assign bank = 1'b0;
  assign act  = vals[0];
`endif

  // A count colliding with a load on the same register is dropped, and so leaves the flags alone.
  assign cnt_go  = (i_INC ^ i_DEC) && in_range(i_CNT_SEL) &&
                   !(i_READ_BUS && (i_BUS_SEL == i_CNT_SEL));
  assign cnt_cur = pick(act, i_CNT_SEL);

  // Enables use the pre-swap bank, so same-cycle operations land in the bank being left.
  always_comb begin
    ld_en  = '0;
    inc_en = '0;
    dec_en = '0;
    for (int bi = 0; bi < NUM_BANKS; bi++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (1'(bi) == bank) begin
          ld_en[bi][r]  = i_READ_BUS && (i_BUS_SEL == SEL_WIDTH'(r));
          inc_en[bi][r] = cnt_go && i_INC && (i_CNT_SEL == SEL_WIDTH'(r));
          dec_en[bi][r] = cnt_go && i_DEC && (i_CNT_SEL == SEL_WIDTH'(r));
        end
      end
    end
  end

  // New value is zero when incrementing all-ones or decrementing one.
  always_comb begin
    wrap_d = wrap_q;
    zero_d = zero_q;
    if (cnt_go) begin
      if (i_INC) begin
        wrap_d = &cnt_cur;
        zero_d = &cnt_cur;
      end else begin
        wrap_d = ~|cnt_cur;
        zero_d = (cnt_cur == DATA_WIDTH'(1));
      end
    end
  end

  always_ff @(posedge i_CLOCK or negedge i_CLEAR_N) begin
    if (!i_CLEAR_N) begin
      wrap_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      zero_q <= zero_d;
    end
  end

  assign BUS      = (i_WRITE_BUS && in_range(i_BUS_SEL)) ? pick(act, i_BUS_SEL) : 'z;
  assign o_DATA_A = pick(act, i_SEL_A);
  assign o_DATA_B = pick(act, i_SEL_B);
  assign o_WRAP   = wrap_q;
  assign o_ZERO   = zero_q;

endmodule

// File: doc/bus_register_bank.md
Name: bus_register_bank

Overview:
- Parametrised bank of NUM_REGS general-purpose registers sharing one tri-state CPU data bus.
- Each register has bus load, bus drive, and in-place increment/decrement.
- Two independent combinational read ports feed the ALU.
- Replaces individual single-register instances in the datapath; register count and width are set per instance.

Parameters:
- DATA_WIDTH, 8, width of each register and of BUS.
- NUM_REGS, 4, number of registers (2..16, need not be a power of two).
- SEL_WIDTH, 2, width of all register-select inputs; must satisfy 2^SEL_WIDTH >= NUM_REGS.

Ports:
- i_CLOCK  input  1  clock; all state changes on rising edge.
- i_CLEAR_N  input  1  asynchronous active-low reset.
- BUS  inout  DATA_WIDTH  main CPU data bus.
- i_BUS_SEL  input  SEL_WIDTH  register addressed by i_READ_BUS / i_WRITE_BUS.
- i_READ_BUS  input  1  load BUS into register i_BUS_SEL at the next edge.
- i_WRITE_BUS  input  1  drive register i_BUS_SEL onto BUS.
- i_CNT_SEL  input  SEL_WIDTH  register targeted by i_INC / i_DEC.
- i_INC  input  1  increment register i_CNT_SEL by 1 (mod 2^DATA_WIDTH).
- i_DEC  input  1  decrement register i_CNT_SEL by 1 (mod 2^DATA_WIDTH).
- i_SEL_A  input  SEL_WIDTH  ALU port A select.
- i_SEL_B  input  SEL_WIDTH  ALU port B select.
- o_DATA_A  output  DATA_WIDTH  contents of register i_SEL_A.
- o_DATA_B  output  DATA_WIDTH  contents of register i_SEL_B.
- o_WRAP  output  1  registered flag: last count operation wrapped.
- o_ZERO  output  1  registered flag: last count result was zero.

Behaviour:
- Reset:
  - i_CLEAR_N low clears all registers, o_WRAP and o_ZERO to 0 immediately, independent of the clock.
  - Outputs hold 0 while reset is asserted.
- Load: with i_READ_BUS=1 at a rising edge, register[i_BUS_SEL] <= BUS. Latency 1 cycle.
- Drive:
  - i_WRITE_BUS=1: BUS = register[i_BUS_SEL] combinationally.
  - Otherwise BUS is all-Z.
- Count: at a rising edge with exactly one of i_INC / i_DEC high, register[i_CNT_SEL] <= value ±1 with modular wrap.
  - o_WRAP <= 1 if INC from all-ones or DEC from 0; otherwise 0.
  - o_ZERO <= (new value == 0).
- Flag hold: o_WRAP and o_ZERO update only on a cycle where a count operation executes; otherwise they hold their value.
- i_INC and i_DEC both high: no operation; register and flags unchanged.
- Priority, same register targeted by both load and count in one cycle: load wins; count is discarded and flags hold.
- Load and count on different registers in the same cycle: both execute.
- i_READ_BUS and i_WRITE_BUS both high, same select: register reloads its own value (no change). This is legal, not an error.
- Out-of-range select (value >= NUM_REGS):
  - Loads and counts are ignored; flags hold.
  - i_WRITE_BUS leaves BUS all-Z.
  - o_DATA_A / o_DATA_B read 0.
- Read-port timing: o_DATA_A / o_DATA_B are combinational from the current register state. A load or count is visible on the read ports in the cycle after its edge; there is no bypass.
- Reset mid-operation: aborts any pending load or count; no partial update.

Optional Feature:
- Macro: REG_BANK_SHADOW_EN.
- With the macro defined:
  - A second (shadow) bank of NUM_REGS registers is added.
  - Extra input i_SWAP (1 bit): on a rising edge with i_SWAP=1, the active bank toggles.
  - Extra output o_BANK (1 bit) reports the active bank; reset value 0.
  - All bus, count and read-port operations address only the active bank.
  - Operations in the same cycle as i_SWAP apply to the bank active before the swap.
  - The inactive bank retains its contents.
  - Reset clears both banks.
- Without the macro: i_SWAP and o_BANK do not exist; single bank only.

Test Plan:
- Reset then read-port sweep: after i_CLEAR_N pulse -> all o_DATA_A/B = 0x00, o_WRAP=0, o_ZERO=0, BUS=Z.
- Bus load and drive:
  - BUS=0x5A, i_BUS_SEL=2, i_READ_BUS for 1 cycle -> next cycle i_SEL_A=2 gives o_DATA_A=0x5A.
  - i_WRITE_BUS, i_BUS_SEL=2 -> BUS=0x5A.
- Wrap on increment: load 0xFF into r1, i_INC with i_CNT_SEL=1 -> r1=0x00, o_WRAP=1, o_ZERO=1.
  - Follow with a second INC -> r1=0x01, o_WRAP=0, o_ZERO=0.
- Simultaneous events:
  - Load 0x10 and INC both targeting r0 -> r0=0x10, flags unchanged.
  - INC+DEC together on r3=0x07 -> r3 stays 0x07.
- Out-of-range with NUM_REGS=3: i_BUS_SEL=3, i_READ_BUS with BUS=0xAA -> no register changes; i_SEL_B=3 -> o_DATA_B=0x00; i_WRITE_BUS -> BUS=Z.
- REG_BANK_SHADOW_EN:
  - Load 0x11 into r0 in bank 0, i_SWAP -> o_BANK=1, o_DATA_A(r0)=0x00.
  - Load 0x22, i_SWAP -> o_BANK=0, r0 reads 0x11.
